// File: rtl/display_source_scheduler.sv
// Time-shares a three-digit BCD display between score and timer sources,
// converting the selected binary value with a sequential double-dabble engine.
module display_source_scheduler #(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned BIN_W       = 10
) (
    input  logic             refclk,
    input  logic             reset,
    input  logic [BIN_W-1:0] score_bin,
    input  logic [BIN_W-1:0] time_bin,
    input  logic             time_en,
    output logic             src_sel,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic             update,
    output logic             busy
);

    localparam int unsigned CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned BW = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(999);
    localparam logic [CW-1:0]    HOLD_END = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    hold_cnt;
    logic [11:0]      bcd, bcd_adj, bcd_shift;
    logic [BIN_W-1:0] sample, sel_val, sat_val;
    logic [BW-1:0]    bitcnt;

    // Source schedule: dropping time_en overrides a coincident wrap.
    always_ff @(posedge refclk) begin
        if (reset || !time_en) begin
            hold_cnt <= '0;
            src_sel  <= 1'b0;
        end else if (hold_cnt == HOLD_END) begin
            hold_cnt <= '0;
            src_sel  <= ~src_sel;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign sel_val = src_sel ? time_bin : score_bin;
    assign sat_val = (sel_val > MAX_VAL) ? MAX_VAL : sel_val;

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_shift = {bcd_adj[10:0], sample[BIN_W-1]};

    always_ff @(posedge refclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        update    = 1'b0;
        case (state)
            IDLE:  state_nxt = LOAD;
            LOAD: begin
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (bitcnt == BW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                update    = 1'b1;
                state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digits load only on the final shift so the display never sees partial values.
    always_ff @(posedge refclk) begin
        if (reset) begin
            bcd      <= '0;
            sample   <= '0;
            bitcnt   <= '0;
            ones     <= '0;
            tens     <= '0;
            hundreds <= '0;
        end else begin
            case (state)
                LOAD: begin
                    sample <= sat_val;
                    bcd    <= '0;
                    bitcnt <= BW'(BIN_W);
                end
                SHIFT: begin
                    bcd    <= bcd_shift;
                    sample <= sample << 1;
                    bitcnt <= bitcnt - 1'b1;
                    if (bitcnt == BW'(1)) begin
                        ones     <= bcd_shift[3:0];
                        tens     <= bcd_shift[7:4];
                        hundreds <= bcd_shift[11:8];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Self-checking bench for display_source_scheduler: directed vectors, multi-cycle
// corner sequences and randomized stimulus against a cycle-level reference model.
module tb_display_source_scheduler;

    localparam int H = 50;

    logic       refclk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] score_bin = '0;
    logic [9:0] time_bin = '0;
    logic       time_en = 1'b0;
    logic       src_sel, update, busy;
    logic [3:0] ones, tens, hundreds;

    display_source_scheduler #(.HOLD_CYCLES(H), .BIN_W(10)) dut (
        .refclk(refclk), .reset(reset), .score_bin(score_bin), .time_bin(time_bin),
        .time_en(time_en), .src_sel(src_sel), .ones(ones), .tens(tens),
        .hundreds(hundreds), .update(update), .busy(busy)
    );

    always #5 refclk = ~refclk;

    int tests = 0;
    int fails = 0;

    // Reference model: position within the 12-cycle conversion (-1 = idle),
    // captured value, displayed value, and hold schedule.
    int m_pos = -1, m_val = 0, m_shown = 0, m_cnt = 0;
    bit m_src = 1'b0;

    typedef struct { int val; int exp; } vec_t;
    vec_t vecs[8];

    function automatic int sat(int v);
        return (v > 999) ? 999 : v;
    endfunction

    function automatic int to_bcd(int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic int digits();
        return int'({hundreds, tens, ones});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int npos = m_pos, nval = m_val, nshown = m_shown, ncnt = m_cnt;
        bit nsrc = m_src;
        if (reset) begin
            npos = -1; nsrc = 1'b0; ncnt = 0; nshown = 0;
        end else begin
            npos = (m_pos == -1 || m_pos == 11) ? 0 : m_pos + 1;
            if (m_pos == 0) nval = sat(m_src ? int'(time_bin) : int'(score_bin));
            if (m_pos == 10) nshown = m_val;
            if (!time_en) begin
                ncnt = 0; nsrc = 1'b0;
            end else if (m_cnt == H - 1) begin
                ncnt = 0; nsrc = ~m_src;
            end else begin
                ncnt = m_cnt + 1;
            end
        end
        @(posedge refclk);
        #1;
        m_pos = npos; m_val = nval; m_shown = nshown; m_cnt = ncnt; m_src = nsrc;
        check("model_src", int'(src_sel), int'(m_src));
        check("model_busy", int'(busy), int'(m_pos >= 0 && m_pos <= 10));
        check("model_update", int'(update), int'(m_pos == 11));
        check("model_digits", digits(), to_bcd(m_shown));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{345, 'h345};
        vecs[1] = '{1023, 'h999};
        vecs[2] = '{0, 'h000};
        vecs[3] = '{9, 'h009};
        vecs[4] = '{10, 'h010};
        vecs[5] = '{99, 'h099};
        vecs[6] = '{100, 'h100};
        vecs[7] = '{999, 'h999};

        // Release at cycle 0 with score 345: exact busy/update timing.
        score_bin = 10'd345;
        do_reset();
        check("rst_digits", digits(), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_update", int'(update), 0);
        check("rst_src", int'(src_sel), 0);
        for (int k = 1; k <= 24; k++) begin
            tick();
            check("seq_busy", int'(busy), int'((k >= 1 && k <= 11) || (k >= 13 && k <= 23)));
            check("seq_update", int'(update), int'(k == 12 || k == 24));
            check("seq_digits", digits(), (k < 12) ? 0 : 'h345);
        end

        // Table: each value must be shown within 23 cycles of the change.
        for (int i = 0; i < 8; i++) begin
            score_bin = 10'(vecs[i].val);
            for (int k = 0; k < 23; k++) tick();
            check("vec_digits", digits(), vecs[i].exp);
        end

        // Mid-SHIFT input change, then reset in the 6th SHIFT cycle.
        score_bin = 10'd111;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            if (k == 5) score_bin = 10'd222;
            tick();
            if (k == 12) check("mid_first", digits(), 'h111);
            if (k == 24) check("mid_second", digits(), 'h222);
        end
        score_bin = 10'd456;
        for (int k = 25; k <= 31; k++) tick();
        reset = 1'b1;
        tick();
        check("abort_digits", digits(), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_update", int'(update), 0);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("fresh_update", int'(update), int'(k == 12));
            check("fresh_digits", digits(), (k < 12) ? 0 : 'h456);
        end

        // Alternation with HOLD 50, then drop time_en on the wrap cycle.
        score_bin = 10'd12;
        time_bin  = 10'd7;
        time_en   = 1'b1;
        do_reset();
        for (int k = 1; k <= 149; k++) begin
            tick();
            check("alt_src", int'(src_sel), (k / 50) % 2);
            if (k == 45)  check("alt_score1", digits(), 'h012);
            if (k == 75)  check("alt_time", digits(), 'h007);
            if (k == 125) check("alt_score2", digits(), 'h012);
        end
        time_en = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            check("drop_src", int'(src_sel), 0);
        end

        // Randomized run against the reference model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) score_bin = 10'($urandom_range(1023));
            if ($urandom_range(7) == 0) time_bin  = 10'($urandom_range(1023));
            if ($urandom_range(199) == 0) time_en = ~time_en;
            reset = ($urandom_range(499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Time-shares the three-digit seven-segment display between two requesters: game score and countdown timer.
- Selects the active source on a hold-time schedule and converts its 10-bit binary value to BCD with a sequential double-dabble engine.
- Drives the ones/tens/hundreds digit inputs of the display top level, which refreshes the digits on the same clock.

Parameters:
- HOLD_CYCLES, 100000000, refclk cycles each source stays on the display while the timer is enabled; legal minimum 2.
- BIN_W, 10, width of the binary source values; maximum displayed value is 999.

Ports:
- refclk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- score_bin  input  BIN_W  score value; binary, unsigned.
- time_bin  input  BIN_W  timer value; binary, unsigned.
- time_en  input  1  1 = alternate between score and timer; 0 = show score only.
- src_sel  output  1  source being converted/shown: 0 = score, 1 = time.
- ones  output  4  BCD ones digit.
- tens  output  4  BCD tens digit.
- hundreds  output  4  BCD hundreds digit.
- update  output  1  one-cycle pulse; new digits are valid in that same cycle.
- busy  output  1  high while a conversion is in progress (LOAD or SHIFT).

Behaviour:
- Reset values: ones/tens/hundreds = 0, src_sel = 0, update = 0, busy = 0, hold counter = 0, FSM = IDLE. A reset asserted mid-conversion aborts it; digits return to 0, not to a partial result.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - Entered only from reset.
  - Moves to LOAD on the first cycle with reset low.
- LOAD (1 cycle):
  - Samples the selected value: score_bin if src_sel = 0, else time_bin.
  - Saturates the sample: values > 999 become 999.
  - Clears the 12-bit BCD shift register and loads the bit counter with BIN_W.
  - busy = 1.
- SHIFT (BIN_W cycles):
  - Each cycle, every BCD nibble >= 5 first gets +3.
  - The {BCD, sample} register then shifts left by 1, and the bit counter decrements.
  - After BIN_W shifts the state moves to DONE.
  - busy = 1.
  - Input changes during SHIFT have no effect, because only the sample captured in LOAD is used.
- Output update on the DONE transition:
  - On the edge that leaves the last SHIFT cycle, ones/tens/hundreds load the BCD result and update goes to 1 for exactly one cycle.
  - Digits are otherwise held, so the display never shows a partial value.
- DONE:
  - Always goes to LOAD next, so conversion runs continuously.
  - Period is 12 cycles: LOAD 1 + SHIFT 10 + DONE 1.
  - Latency from an input change to the digits is at most 23 cycles.
- Hold counter and source switching:
  - If time_en = 1, the counter increments each cycle.
  - At HOLD_CYCLES-1 the counter wraps to 0 and src_sel toggles.
  - The new source takes effect at the next LOAD; a conversion already in flight finishes with the old source.
  - src_sel labels the source being converted, not the digits currently shown; it leads the digits by up to one conversion.
- time_en = 0:
  - The counter is held at 0 and src_sel is cleared to 0 on the next edge.
  - When time_en returns to 1, counting restarts from 0 with score shown first.
- Simultaneous wrap and time_en falling in the same cycle: time_en wins (src_sel = 0, counter = 0).
- Arithmetic: the BCD nibbles never exceed 9 after correction. Saturation guarantees the hundreds digit is ≤ 9, with no overflow beyond 12 BCD bits.

Test Plan:
- Reset then release at cycle 0, score_bin = 345, time_en = 0:
  - busy = 1 in cycles 1–11.
  - update = 1 in cycle 12 with hundreds/tens/ones = 3/4/5.
  - update pulses again every 12 cycles.
  - Before cycle 12 all digits read 0.
- score_bin = 1023:
  - Digits = 9/9/9.
  - Then score_bin = 0, 9, 10, 99, 100, 999: each appears correctly within 23 cycles of the change.
- Change score_bin from 111 to 222 at cycle 5 (mid-SHIFT): the cycle-12 update shows 1/1/1, and the cycle-24 update shows 2/2/2.
- HOLD_CYCLES = 50, time_en = 1, score = 12, time = 7:
  - src_sel toggles every 50 cycles.
  - Digits alternate 0/1/2 and 0/0/7, each change following the src_sel toggle within 23 cycles.
  - Drop time_en at the wrap cycle: src_sel goes to 0 and stays 0.
- Reset asserted in the 6th SHIFT cycle:
  - Next cycle: digits = 0, busy = 0, update = 0.
  - After release, a fresh full 12-cycle conversion is produced.
